// File: rtl/step_pulse_gen_pkg.sv
// Shared types for the step pulse generator: FSM state and repeat-phase encodings.
package step_pulse_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE         = 2'b00,
        S_PRESS_WAIT   = 2'b01,
        S_HELD         = 2'b10,
        S_RELEASE_WAIT = 2'b11
    } state_e;

    typedef enum logic {
        PH_DLY = 1'b0,
        PH_PER = 1'b1
    } phase_e;

    // Larger of two parameters; sizes the shared repeat counter.
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Button-side bundle of the step pulse generator.
interface step_pulse_gen_if;
    logic       btn_in;
    logic       rpt_en;
    logic       step;
    logic       pressed;
    logic [1:0] state_dbg;

    modport master (
        output btn_in, rpt_en,
        input  step, pressed, state_dbg
    );

    modport slave (
        input  btn_in, rpt_en,
        output step, pressed, state_dbg
    );
endinterface

// File: rtl/step_pulse_gen_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; cleared synchronously.
module sync_2ff (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic q_q;

    // Capture stage followed by the settled stage.
    always_ff @(posedge clk) begin
        if (clr) begin
            meta_q <= 1'b0;
            q_q    <= 1'b0;
        end else begin
            meta_q <= d;
            q_q    <= meta_q;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/step_pulse_gen.sv
// Debounced push-button to single-cycle step strobe, with optional auto-repeat.
module step_pulse_gen
    import step_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned REPEAT_DLY   = 25_000_000,
    parameter int unsigned REPEAT_PER   = 10_000_000
) (
    input  logic             clk,
    input  logic             clr,
    step_pulse_gen_if.slave  bus
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC);
    localparam int unsigned RPT_W = $clog2(max2(REPEAT_DLY, REPEAT_PER));

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);

    logic btn_s;

    state_e           state_q,   state_d;
    phase_e           phase_q,   phase_d;
    logic [DB_W-1:0]  db_cnt_q,  db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             step_q,    step_d;
    logic             pressed_q, pressed_d;

    sync_2ff u_sync (
        .clk (clk),
        .clr (clr),
        .d   (bus.btn_in),
        .q   (btn_s)
    );

    // State and counter registers; clr dominates everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_DLY;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
            step_q    <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            step_q    <= step_d;
            pressed_q <= pressed_d;
        end
    end

    // Next-state logic: debounce on press/release, repeat timing while held.
    // Leaving HELD takes priority over a repeat that would fire in the same cycle.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        db_cnt_d  = db_cnt_q;
        rpt_cnt_d = rpt_cnt_q;
        step_d    = 1'b0;
        pressed_d = pressed_q;

        case (state_q)
            S_IDLE: begin
                if (btn_s) begin
                    state_d  = S_PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end

            S_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = S_HELD;
                    db_cnt_d  = '0;
                    step_d    = 1'b1;
                    pressed_d = 1'b1;
                    rpt_cnt_d = '0;
                    phase_d   = PH_DLY;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            S_HELD: begin
                if (!btn_s) begin
                    state_d   = S_RELEASE_WAIT;
                    db_cnt_d  = '0;
                    rpt_cnt_d = '0;
                    phase_d   = PH_DLY;
                end else if (!bus.rpt_en) begin
                    rpt_cnt_d = '0;
                    phase_d   = PH_DLY;
                end else if (phase_q == PH_DLY && rpt_cnt_q == DLY_LAST) begin
                    step_d    = 1'b1;
                    rpt_cnt_d = '0;
                    phase_d   = PH_PER;
                end else if (phase_q == PH_PER && rpt_cnt_q == PER_LAST) begin
                    step_d    = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end

            S_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d   = S_HELD;
                    db_cnt_d  = '0;
                    rpt_cnt_d = '0;
                    phase_d   = PH_DLY;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = S_IDLE;
                    db_cnt_d  = '0;
                    pressed_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.step      = step_q;
    assign bus.pressed   = pressed_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen against a run-length reference model.
module tb_step_pulse_gen;

    localparam int unsigned D   = 4;
    localparam int unsigned DLY = 8;
    localparam int unsigned PER = 3;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    step_pulse_gen_if ifc ();

    step_pulse_gen #(
        .DEBOUNCE_CYC (D),
        .REPEAT_DLY   (DLY),
        .REPEAT_PER   (PER)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (ifc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: button seen two edges late; a press is accepted after D+1
    // consecutive high samples, a release after D+1 consecutive low samples.
    // "age" counts edges spent held with repeat enabled since the last press/bounce.
    int   m_s1 = 0, m_s2 = 0, m_b = 0, m_prev_b = 0;
    int   m_pressed = 0, m_ones = 0, m_zeros = 0, m_age = 0;
    logic       exp_step    = 1'b0;
    logic       exp_pressed = 1'b0;
    logic [1:0] exp_state   = 2'd0;

    always @(posedge clk) begin
        if (clr) begin
            m_s1 = 0; m_s2 = 0; m_prev_b = 0;
            m_pressed = 0; m_ones = 0; m_zeros = 0; m_age = 0;
            exp_step = 1'b0;
        end else begin
            m_b  = m_s2;
            m_s2 = m_s1;
            m_s1 = (ifc.btn_in === 1'b1) ? 1 : 0;
            exp_step = 1'b0;
            if (m_pressed == 0) begin
                m_ones = (m_b != 0) ? m_ones + 1 : 0;
                if (m_ones == D + 1) begin
                    m_pressed = 1; exp_step = 1'b1;
                    m_ones = 0; m_zeros = 0; m_age = 0;
                end
            end else if (m_b == 0) begin
                m_age = 0;
                m_zeros++;
                if (m_zeros == D + 1) begin
                    m_pressed = 0; m_zeros = 0;
                end
            end else begin
                m_zeros = 0;
                if (m_prev_b != 0 && ifc.rpt_en === 1'b1) begin
                    m_age++;
                    if (m_age == DLY || (m_age > DLY && (m_age - DLY) % PER == 0))
                        exp_step = 1'b1;
                end else begin
                    m_age = 0;
                end
            end
            m_prev_b = m_b;
        end
        exp_pressed = (m_pressed != 0);
        if (m_pressed == 0) exp_state = (m_ones > 0) ? 2'd1 : 2'd0;
        else                exp_state = (m_prev_b != 0) ? 2'd2 : 2'd3;
    end

    task automatic test_reset();
        clr = 1'b1; ifc.btn_in = 1'b0; ifc.rpt_en = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_in_clr edge %0d: got %b want 0000", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg});
            end
        end
        clr = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_idle edge %0d: got %b want 0000", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg});
            end
        end
    endtask

    task automatic test_press();
        ifc.btn_in = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ifc.step, ifc.pressed} !== {1'(n == 7), 1'(n >= 7)}) begin
                n_bad++;
                $display("FAIL press_latency edge %0d: step,pressed got %b want %b", n,
                         {ifc.step, ifc.pressed}, {1'(n == 7), 1'(n >= 7)});
            end
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== {exp_step, exp_pressed, exp_state}) begin
                n_bad++;
                $display("FAIL press_model edge %0d: got %b want %b", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg}, {exp_step, exp_pressed, exp_state});
            end
        end
        n_cmp++;
        if (ifc.state_dbg !== 2'b10) begin
            n_bad++;
            $display("FAIL press_state: got %b want 10", ifc.state_dbg);
        end
        ifc.btn_in = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== {exp_step, exp_pressed, exp_state}) begin
                n_bad++;
                $display("FAIL press_release_model edge %0d: got %b want %b", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg}, {exp_step, exp_pressed, exp_state});
            end
        end
        n_cmp++;
        if ({ifc.pressed, ifc.state_dbg} !== 3'b000) begin
            n_bad++;
            $display("FAIL press_back_idle: got %b want 000", {ifc.pressed, ifc.state_dbg});
        end
    endtask

    task automatic test_glitch();
        int saw_pw = 0;
        int steps  = 0;
        for (int n = 1; n <= 12; n++) begin
            ifc.btn_in = (n <= 2) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (ifc.state_dbg === 2'b01) saw_pw = 1;
            if (ifc.step === 1'b1) steps++;
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== {exp_step, exp_pressed, exp_state}) begin
                n_bad++;
                $display("FAIL glitch_model edge %0d: got %b want %b", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg}, {exp_step, exp_pressed, exp_state});
            end
        end
        n_cmp++;
        if (saw_pw != 1 || steps != 0 || ifc.state_dbg !== 2'b00) begin
            n_bad++;
            $display("FAIL glitch_dropped: saw_pw=%0d steps=%0d state=%b want 1 0 00",
                     saw_pw, steps, ifc.state_dbg);
        end
    endtask

    task automatic test_release_bounce();
        int saw_rw = 0, back_held = 0, steps = 0, drop_edge = 0;
        ifc.btn_in = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== {exp_step, exp_pressed, exp_state}) begin
                n_bad++;
                $display("FAIL bounce_press_model edge %0d: got %b want %b", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg}, {exp_step, exp_pressed, exp_state});
            end
        end
        // low 3 edges, high 2 edges (re-bounce), then the final stable release
        for (int n = 1; n <= 5; n++) begin
            ifc.btn_in = (n >= 4) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (ifc.state_dbg === 2'b11) saw_rw = 1;
            if (ifc.step === 1'b1) steps++;
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== {exp_step, exp_pressed, exp_state}) begin
                n_bad++;
                $display("FAIL bounce_model edge %0d: got %b want %b", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg}, {exp_step, exp_pressed, exp_state});
            end
        end
        ifc.btn_in = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (n <= 2 && ifc.state_dbg === 2'b10 && saw_rw == 1) back_held = 1;
            if (ifc.step === 1'b1) steps++;
            if (drop_edge == 0 && ifc.pressed === 1'b0) drop_edge = n;
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== {exp_step, exp_pressed, exp_state}) begin
                n_bad++;
                $display("FAIL release_model edge %0d: got %b want %b", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg}, {exp_step, exp_pressed, exp_state});
            end
        end
        n_cmp++;
        if (saw_rw != 1 || back_held != 1 || steps != 0) begin
            n_bad++;
            $display("FAIL bounce_no_step: saw_rw=%0d back_held=%0d steps=%0d want 1 1 0",
                     saw_rw, back_held, steps);
        end
        n_cmp++;
        if (drop_edge != D + 3) begin
            n_bad++;
            $display("FAIL release_latency: pressed dropped at edge %0d want %0d", drop_edge, D + 3);
        end
    endtask

    task automatic test_repeat();
        logic want;
        ifc.btn_in = 1'b1; ifc.rpt_en = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            want = (n == 7) || (n >= 15 && (n - 15) % 3 == 0);
            n_cmp++;
            if (ifc.step !== want) begin
                n_bad++;
                $display("FAIL repeat_timing edge %0d: step got %b want %b", n, ifc.step, want);
            end
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== {exp_step, exp_pressed, exp_state}) begin
                n_bad++;
                $display("FAIL repeat_model edge %0d: got %b want %b", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg}, {exp_step, exp_pressed, exp_state});
            end
        end
        ifc.rpt_en = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ifc.step !== 1'b0) begin
                n_bad++;
                $display("FAIL repeat_disabled edge %0d: step got %b want 0", n, ifc.step);
            end
        end
        ifc.rpt_en = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ifc.step !== 1'(n == 8)) begin
                n_bad++;
                $display("FAIL repeat_reenable edge %0d: step got %b want %b", n, ifc.step, 1'(n == 8));
            end
        end
        ifc.btn_in = 1'b0; ifc.rpt_en = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== {exp_step, exp_pressed, exp_state}) begin
                n_bad++;
                $display("FAIL repeat_release_model edge %0d: got %b want %b", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg}, {exp_step, exp_pressed, exp_state});
            end
        end
    endtask

    task automatic test_clr_held();
        ifc.btn_in = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if ({ifc.pressed, ifc.state_dbg} !== 3'b110) begin
            n_bad++;
            $display("FAIL clr_precond: got %b want 110", {ifc.pressed, ifc.state_dbg});
        end
        clr = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({ifc.step, ifc.pressed, ifc.state_dbg} !== 4'b0000) begin
            n_bad++;
            $display("FAIL clr_while_held: got %b want 0000", {ifc.step, ifc.pressed, ifc.state_dbg});
        end
        clr = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ifc.step, ifc.pressed} !== {1'(n == 7), 1'(n >= 7)}) begin
                n_bad++;
                $display("FAIL clr_redebounce edge %0d: step,pressed got %b want %b", n,
                         {ifc.step, ifc.pressed}, {1'(n == 7), 1'(n >= 7)});
            end
        end
        ifc.btn_in = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int   run_left = 0;
        logic prev_step = 1'b0;
        for (int n = 1; n <= 1500; n++) begin
            if (run_left == 0) begin
                ifc.btn_in = ~ifc.btn_in;
                run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
            end
            run_left--;
            if ($urandom_range(0, 19) == 0) ifc.rpt_en = ~ifc.rpt_en;
            clr = ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if ({ifc.step, ifc.pressed, ifc.state_dbg} !== {exp_step, exp_pressed, exp_state}) begin
                n_bad++;
                $display("FAIL random_model edge %0d: got %b want %b", n,
                         {ifc.step, ifc.pressed, ifc.state_dbg}, {exp_step, exp_pressed, exp_state});
            end
            n_cmp++;
            if (prev_step === 1'b1 && ifc.step === 1'b1) begin
                n_bad++;
                $display("FAIL random_double_step edge %0d: step got 1 want 0", n);
            end
            prev_step = ifc.step;
        end
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; ifc.btn_in = 1'b0; ifc.rpt_en = 1'b0;
        test_reset();
        test_press();
        test_glitch();
        test_release_bounce();
        test_repeat();
        test_clr_held();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
